// File: rtl/uart_pkg.sv
// Shared UART definitions: the line-side state encoding and default bit timing,
// common to the transmit buffer and the matching receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 1155;
    localparam int unsigned BITS_PER_BYTE        = 8;

    // Width of a counter that must hold 0..clks-1 (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with read/write pointers and an occupancy count.
// Head byte is presented combinationally on rd_data_o; wr_ready_o is registered
// from the next-state count so it is valid right after each edge.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     rd_en_i,
    output logic [7:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     wr_ready_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          wr_ready_q;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en_i && wr_ready_q;
    assign do_rd = rd_en_i && (count_q != '0);

    // Occupancy next state: a simultaneous write and read leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, count and write-ready; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            wr_ready_q <= (count_d != CW'(DEPTH));
        end
    end

    // Storage array needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign wr_ready_o = wr_ready_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a registered-output
// transmit FSM. Back-to-back frames are issued with no idle cycle between them.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          osc_clk,
    input  logic                          rst_n,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow
);

    localparam int unsigned           CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]         CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]         CNT_LAST = CW'(CLKS_PER_BIT - 2);

    uart_state_e                   state_q;
    logic [CW-1:0]                 cnt_q;
    logic [2:0]                    bit_idx_q;
    logic [7:0]                    shift_q;
    logic                          serial_q;
    logic                          active_q;
    logic                          done_q;
    logic                          overflow_q;

    logic                          fifo_wr_ready;
    logic [7:0]                    fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          fifo_has_data;
    logic                          fifo_pop;
    logic                          bit_end;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (osc_clk),
        .rst_ni     (rst_n),
        .wr_en_i    (i_Tx_DV),
        .wr_data_i  (i_Tx_Byte),
        .rd_en_i    (fifo_pop),
        .rd_data_o  (fifo_rd_data),
        .count_o    (fifo_count),
        .wr_ready_o (fifo_wr_ready)
    );

    assign fifo_has_data = (fifo_count != '0);
    assign bit_end       = (cnt_q == CNT_MAX);
    // Pop from IDLE, or at the very end of a stop bit so the next start bit follows directly.
    assign fifo_pop      = fifo_has_data && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    // Transmit FSM with bit timer and shifter; every line-side output is a register.
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q    <= '0;
                    serial_q <= 1'b1;
                    active_q <= 1'b0;
                    if (fifo_pop) begin
                        shift_q  <= fifo_rd_data;
                        serial_q <= 1'b0;
                        active_q <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        serial_q  <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'(BITS_PER_BYTE - 1)) begin
                            serial_q <= 1'b1;
                            state_q  <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            serial_q  <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (fifo_pop) begin
                            shift_q  <= fifo_rd_data;
                            serial_q <= 1'b0;
                            state_q  <= START;
                        end else begin
                            serial_q <= 1'b1;
                            active_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Raise Done one edge early so it is high during the last stop cycle.
                        if (cnt_q == CNT_LAST) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Sticky flag: any write offered while the FIFO reports full.
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (i_Tx_DV && !fifo_wr_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_Tx_Ready   = fifo_wr_ready;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;
    assign o_Fifo_Count = fifo_count;
    assign o_Overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a serial
// line decoder that reassembles transmitted bytes.
`timescale 1ns/1ps
module tb_uart_tx_buf;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          osc_clk   = 1'b0;
    logic          rst_n     = 1'b0;
    logic          i_Tx_DV   = 1'b0;
    logic [7:0]    i_Tx_Byte = 8'h00;
    logic          o_Tx_Ready;
    logic          o_Tx_Serial;
    logic          o_Tx_Active;
    logic          o_Tx_Done;
    logic [CW-1:0] o_Fifo_Count;
    logic          o_Overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rx_q[$];
    int         frame_err = 0;
    logic       mon_busy  = 1'b0;
    int         mon_cnt   = 0;
    logic [7:0] mon_bits  = 8'h00;

    uart_tx_buf #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .osc_clk      (osc_clk),
        .rst_n        (rst_n),
        .i_Tx_DV      (i_Tx_DV),
        .i_Tx_Byte    (i_Tx_Byte),
        .o_Tx_Ready   (o_Tx_Ready),
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done),
        .o_Fifo_Count (o_Fifo_Count),
        .o_Overflow   (o_Overflow)
    );

    always #5 osc_clk = ~osc_clk;

    // Line decoder: first low sample is cycle 0; bit n is sampled at cycle 4n+2.
    always @(negedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_busy <= 1'b0;
            mon_cnt  <= 0;
        end else if (!mon_busy) begin
            if (o_Tx_Serial == 1'b0) begin
                mon_busy <= 1'b1;
                mon_cnt  <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == 2 && o_Tx_Serial !== 1'b0) begin
                frame_err <= frame_err + 1;
            end
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) begin
                mon_bits[(mon_cnt - 6) / 4] <= o_Tx_Serial;
            end
            if (mon_cnt == 38) begin
                rx_q.push_back(mon_bits);
                if (o_Tx_Serial !== 1'b1) begin
                    frame_err <= frame_err + 1;
                end
                mon_busy <= 1'b0;
            end
        end
    end

    typedef struct {
        logic       dv;
        logic [7:0] data;
        logic [7:0] exp;   // {serial, active, done, ready, overflow, count[2:0]}
    } vec_t;

    vec_t vecs[42];

    function automatic logic [7:0] obs();
        return {o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ready, o_Overflow, o_Fifo_Count};
    endfunction

    function automatic logic [7:0] pack(input logic ser, input logic act, input logic dn,
                                        input logic rdy, input logic ovf, input int cnt);
        return {ser, act, dn, rdy, ovf, 3'(cnt)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge osc_clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((o_Tx_Active || o_Fifo_Count != '0) && n < 2000) begin
            tick();
            n++;
        end
        chk("idle_reached", (n < 2000), 1);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : main
        logic a5_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int   ov_cnt[6]  = '{1, 1, 2, 3, 4, 4};
        logic ov_rdy[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic ov_ovf[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   done_at[$];
        int   gaps;
        int   lows;
        int   sent;
        int   n;

        // Single 0xA5 frame, one vector per edge k+j.
        vecs[0] = '{dv: 1'b1, data: 8'hA5, exp: pack(1, 0, 0, 1, 0, 1)};
        for (int j = 1; j <= 40; j++) begin
            logic ser;
            if (j <= 4)       ser = 1'b0;
            else if (j <= 36) ser = a5_bits[(j - 5) / 4];
            else              ser = 1'b1;
            vecs[j] = '{dv: 1'b0, data: 8'h00, exp: pack(ser, 1, (j == 40), 1, 0, 0)};
        end
        vecs[41] = '{dv: 1'b0, data: 8'h00, exp: pack(1, 0, 0, 1, 0, 0)};

        // Reset values, during and just after reset.
        repeat (3) tick();
        chk("reset_in", obs(), pack(1, 0, 0, 1, 0, 0));
        rst_n = 1'b1;
        tick();
        chk("reset_out", obs(), pack(1, 0, 0, 1, 0, 0));

        // Single write, cycle-accurate waveform.
        rx_q.delete();
        for (int j = 0; j < 42; j++) begin
            i_Tx_DV   = vecs[j].dv;
            i_Tx_Byte = vecs[j].data;
            tick();
            chk($sformatf("a5_vec%0d", j), obs(), vecs[j].exp);
        end
        i_Tx_DV = 1'b0;
        wait_idle();
        chk("a5_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("a5_rx", rx_q[0], 8'hA5);

        // Burst of three back-to-back frames.
        rx_q.delete();
        gaps = 0;
        for (int j = 0; j <= 122; j++) begin
            i_Tx_DV   = (j < 3);
            i_Tx_Byte = 8'(j + 1);
            tick();
            if (o_Tx_Done) done_at.push_back(j);
            if (j >= 1 && j <= 120 && !o_Tx_Active) gaps++;
        end
        i_Tx_DV = 1'b0;
        chk("burst_gaps", gaps, 0);
        chk("burst_active_end", o_Tx_Active, 0);
        chk("burst_done_n", done_at.size(), 3);
        for (int i = 0; i < done_at.size() && i < 3; i++) begin
            chk($sformatf("burst_done%0d", i), done_at[i], 40 * (i + 1));
        end
        wait_idle();
        chk("burst_rx_n", rx_q.size(), 3);
        for (int i = 0; i < rx_q.size() && i < 3; i++) begin
            chk($sformatf("burst_rx%0d", i), rx_q[i], i + 1);
        end

        // Six writes into a depth-4 FIFO while the first frame runs.
        rx_q.delete();
        for (int j = 0; j < 6; j++) begin
            i_Tx_DV   = 1'b1;
            i_Tx_Byte = 8'(8'h10 + j);
            tick();
            chk($sformatf("ovf_cnt%0d", j), o_Fifo_Count, ov_cnt[j]);
            chk($sformatf("ovf_rdy%0d", j), o_Tx_Ready, ov_rdy[j]);
            chk($sformatf("ovf_flag%0d", j), o_Overflow, ov_ovf[j]);
        end
        i_Tx_DV = 1'b0;
        wait_idle();
        chk("ovf_sticky", o_Overflow, 1);
        chk("ovf_rx_n", rx_q.size(), 5);
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            chk($sformatf("ovf_rx%0d", i), rx_q[i], 8'h10 + i);
        end
        do_reset();
        chk("ovf_cleared", o_Overflow, 0);

        // Asynchronous reset in the middle of frame 0x3C with two bytes queued.
        rx_q.delete();
        for (int j = 0; j <= 17; j++) begin
            i_Tx_DV   = (j < 3);
            i_Tx_Byte = 8'(8'h3C + j);
            tick();
        end
        i_Tx_DV = 1'b0;
        chk("mid_pre_cnt", o_Fifo_Count, 2);
        chk("mid_pre_act", o_Tx_Active, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", obs(), pack(1, 0, 0, 1, 0, 0));
        repeat (2) tick();
        rst_n = 1'b1;
        lows = 0;
        for (int j = 0; j < 100; j++) begin
            tick();
            if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) lows++;
        end
        chk("mid_no_resume", lows, 0);
        chk("mid_rx_n", rx_q.size(), 0);
        chk("mid_cnt", o_Fifo_Count, 0);

        // Write landing on the same edge as the stop-end pop, with two queued.
        rx_q.delete();
        for (int j = 0; j <= 41; j++) begin
            i_Tx_DV   = (j < 3) || (j == 41);
            i_Tx_Byte = (j == 41) ? 8'h44 : 8'(8'h41 + j);
            tick();
            if (j == 40) begin
                chk("coin_done", o_Tx_Done, 1);
                chk("coin_cnt_before", o_Fifo_Count, 2);
            end
        end
        i_Tx_DV = 1'b0;
        chk("coin_cnt_after", o_Fifo_Count, 2);
        chk("coin_active", o_Tx_Active, 1);
        chk("coin_serial", o_Tx_Serial, 0);
        wait_idle();
        chk("coin_rx_n", rx_q.size(), 4);
        for (int i = 0; i < rx_q.size() && i < 4; i++) begin
            chk($sformatf("coin_rx%0d", i), rx_q[i], 8'h41 + i);
        end

        // All 256 byte values, paced by o_Tx_Ready.
        rx_q.delete();
        sent = 0;
        n    = 0;
        while (sent < 256 && n < 20000) begin
            i_Tx_DV   = o_Tx_Ready;
            i_Tx_Byte = 8'(sent);
            tick();
            if (i_Tx_DV) sent++;
            n++;
        end
        i_Tx_DV = 1'b0;
        chk("lb_sent", sent, 256);
        n = 0;
        while (rx_q.size() < 256 && n < 20000) begin
            tick();
            n++;
        end
        chk("lb_rx_n", rx_q.size(), 256);
        for (int i = 0; i < rx_q.size() && i < 256; i++) begin
            chk($sformatf("lb_rx%0d", i), rx_q[i], i);
        end
        chk("lb_overflow", o_Overflow, 0);
        chk("frame_errors", frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
